// File: rtl/fifo_pkg.sv
// Shared definitions for sync_fifo: default geometry, status flag bundle and
// the count-to-flag decode used by the FIFO and by anything modelling it.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;

  typedef struct packed {
    logic full;
    logic empty;
    logic half;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Flags depend on occupancy alone, so a registered count yields registered-quality flags.
  function automatic fifo_status_t calc_status(input int cnt, input int depth,
                                               input int afull_thresh,
                                               input int aempty_thresh);
    fifo_status_t st;
    st.full         = (cnt == depth);
    st.empty        = (cnt == 0);
    st.half         = (cnt >= depth / 2);
    st.almost_full  = (cnt >= afull_thresh);
    st.almost_empty = (cnt <= aempty_thresh);
    return st;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo: one write port, one read port, single clock.
// REG_READ selects a registered read (1-cycle latency) or a combinational read.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter bit REG_READ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  if (REG_READ) begin : g_reg_read
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (re) begin
        rdata_q <= mem[raddr];
      end
    end

    assign rdata = rdata_q;
  end else begin : g_comb_read
    logic unused_rd_ctrl;

    assign unused_rd_ctrl = rst ^ re;
    assign rdata          = mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, status flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  half,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit REG_READ = 1'b0;
`else
  localparam bit REG_READ = 1'b1;
`endif

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  if (!(AEMPTY_THRESH > 0 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH))
  begin : g_bad_thresh
    $error("sync_fifo: need 0 < AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_d;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;
  fifo_status_t          status;

  assign status = calc_status(int'(count_q), DEPTH, AFULL_THRESH, AEMPTY_THRESH);

  // A read never sees a same-cycle write (no bypass); a write at full needs a paired read.
  assign rd_acc = rd_en && !status.empty;
  assign wr_acc = wr_en && (!status.full || rd_acc);

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q     <= '0;
      raddr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        waddr_q <= waddr_q + ADDR_ONE;
      end
      if (rd_acc) begin
        raddr_q <= raddr_q + ADDR_ONE;
      end
      count_q <= count_d;
      if (wr_en && !wr_acc) begin
        overflow_q <= 1'b1;
      end
      if (rd_en && !rd_acc) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Requests in the reset cycle must not touch storage or the read register.
  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_READ   (REG_READ)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && !rst),
    .waddr (waddr_q),
    .wdata (data_in),
    .re    (rd_acc && !rst),
    .raddr (raddr_q),
    .rdata (data_out)
  );

  assign full         = status.full;
  assign empty        = status.empty;
  assign half         = status.half;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed plus randomised bench for sync_fifo, checked against a queue scoreboard.
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int AF    = 60;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, half, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int            n_checks = 0;
  int            n_fail   = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] m_last = '0;
  logic          m_ovf  = 1'b0;
  logic          m_unf  = 1'b0;

  sync_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .half         (half),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    fifo_status_t st;
    st = calc_status(q.size(), DEPTH, AF, AE);
    chk("count", 32'(count), 32'(q.size()));
    chk("full", full, st.full);
    chk("empty", empty, st.empty);
    chk("half", half, st.half);
    chk("almost_full", almost_full, st.almost_full);
    chk("almost_empty", almost_empty, st.almost_empty);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
  endtask

  task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] din);
    logic          racc, wacc;
    logic [DW-1:0] exp_rd;
    racc   = rd && (q.size() != 0);
    wacc   = wr && (q.size() < DEPTH || racc);
    exp_rd = racc ? q[0] : m_last;
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
`ifdef SYNC_FIFO_FWFT_EN
    if (racc) chk("fwft_head", data_out, exp_rd);
`endif
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (racc) begin
      void'(q.pop_front());
      m_last = exp_rd;
    end
    if (wacc) q.push_back(din);
    if (wr && !wacc) m_ovf = 1'b1;
    if (rd && !racc) m_unf = 1'b1;
    check_state();
`ifndef SYNC_FIFO_FWFT_EN
    chk("data_out", data_out, m_last);
`endif
  endtask

  // Requests held high during reset must be ignored and raise no error flag.
  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    check_state();
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_data_out", data_out, 0);
`endif
  endtask

  initial begin
    int words;
    int cycles;
    bit did_rst;

    @(posedge clk);
    #1;
    do_reset();

    // Fill to full, then one rejected write.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i));
    chk("full_after_64", full, 1'b1);
    chk("count_64", 32'(count), 64);
    cycle(1'b1, 1'b0, 8'hEE);
    chk("ovf_on_65th", overflow, 1'b1);
    chk("count_stays_64", 32'(count), 64);

    // Drain in order, then one rejected read.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
    chk("empty_after_drain", empty, 1'b1);
    cycle(1'b0, 1'b1, 8'h00);
    chk("unf_on_extra_read", underflow, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("data_out_holds_3f", data_out, 8'h3F);
`endif

    // Simultaneous read and write at full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i + 8'h40));
    cycle(1'b1, 1'b1, 8'hAA);
    chk("rw_full_count", 32'(count), 64);
    chk("rw_full_no_ovf", overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
    chk("last_word_aa", data_out, 8'hAA);
`endif

    // Simultaneous read and write at empty.
    cycle(1'b1, 1'b1, 8'h55);
    chk("rw_empty_count", 32'(count), 1);
    chk("rw_empty_unf", underflow, 1'b1);

    // Threshold walk.
    do_reset();
    for (int i = 1; i <= AF; i++) begin
      cycle(1'b1, 1'b0, DW'(i));
      if (i == 4)  chk("ae_at_4", almost_empty, 1'b1);
      if (i == 5)  chk("ae_at_5", almost_empty, 1'b0);
      if (i == 31) chk("half_at_31", half, 1'b0);
      if (i == 32) chk("half_at_32", half, 1'b1);
      if (i == 59) chk("af_at_59", almost_full, 1'b0);
      if (i == 60) chk("af_at_60", almost_full, 1'b1);
    end

    // Random stream of 200 accepted writes with one reset mid-stream.
    do_reset();
    words   = 0;
    cycles  = 0;
    did_rst = 1'b0;
    while (words < 200 && cycles < 3000) begin
      logic wr, rd;
      if (!did_rst && words == 90) begin
        do_reset();
        did_rst = 1'b1;
      end
      wr = ($urandom_range(99) < 65);
      rd = ($urandom_range(99) < 55);
      if (wr && (q.size() < DEPTH || (rd && q.size() != 0))) words++;
      cycle(wr, rd, DW'($urandom));
      cycles++;
    end
    chk("stream_budget", 32'(words), 200);
    chk("stream_reset_seen", did_rst, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
